// File: rtl/serial_signed_subtractor.sv
// serial_signed_subtractor
// Bit-serial two's-complement subtractor: Result = A - B, one bit per clock.
// Operands are sign-extended to WIDTH+1 bits so the difference always fits.
// The result is sign-extended to WIDTH+2 bits to match the downstream mux.
// Start/Busy/Done handshake. Result, Sel and Overflow hold between ops.
// Optional feature: define SUB_OVERFLOW_FLAG_EN to enable the Overflow flag.
// Without it, Overflow is tied low.
module serial_signed_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH+1:0] Result,
  output logic             Sel,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow
);

  localparam int RES_W = WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_sr_q, b_sr_q;   // operand shift registers, LSB consumed first
  logic [WIDTH-1:0] acc_q;            // low difference bits, newest enters at MSB
  logic [CNT_W-1:0] count_q;
  logic             carry_q;
  logic             accept;           // Start taken this cycle (IDLE or DONE)
  logic             last;             // final SHIFT cycle, MSB of difference produced
  logic             b_inv;
  logic             sum;
  logic             carry_n;
  logic [WIDTH:0]   diff_final;       // full difference, valid when last is high

  // One full-adder slice computing a + ~b + carry; carry starts at 1.
  assign b_inv      = ~b_sr_q[0];
  assign sum        = a_sr_q[0] ^ b_inv ^ carry_q;
  assign carry_n    = (a_sr_q[0] & b_inv) | (a_sr_q[0] & carry_q) | (b_inv & carry_q);
  assign diff_final = {sum, acc_q};

  assign Busy = (state_q == SHIFT);
  assign Done = (state_q == DONE);

  // State register.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and handshake decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q == CNT_W'(WIDTH)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial datapath: latch operands on accept, shift one bit per SHIFT cycle,
  // publish the sign-extended result on the edge that enters DONE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: shift registers are cleared on reset (not left to power-up value)
      // so an aborted op leaves no stale bits behind.
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      Result  <= '0;
      Sel     <= 1'b0;
    end else if (accept) begin
      a_sr_q  <= {A[WIDTH-1], A};
      b_sr_q  <= {B[WIDTH-1], B};
      acc_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b1;
      Sel     <= 1'b0;
    end else if (state_q == SHIFT) begin
      a_sr_q  <= a_sr_q >> 1;
      b_sr_q  <= b_sr_q >> 1;
      acc_q   <= {sum, acc_q[WIDTH-1:1]};
      count_q <= count_q + 1'b1;
      carry_q <= carry_n;
      if (last) begin
        Result <= RES_W'({diff_final[WIDTH], diff_final});
        Sel    <= 1'b1;
      end
    end
  end

`ifdef SUB_OVERFLOW_FLAG_EN
  logic overflow_q;

  // Overflow: difference outside the WIDTH-bit signed range (top two bits differ).
  always_ff @(posedge Clock) begin
    if (Reset)     overflow_q <= 1'b0;
    else if (last) overflow_q <= diff_final[WIDTH] ^ diff_final[WIDTH-1];
  end

  assign Overflow = overflow_q;
`else
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_signed_subtractor.sv
// Self-checking bench for serial_signed_subtractor (WIDTH = 4).
// Overflow expectations follow SUB_OVERFLOW_FLAG_EN when it is defined.
module tb_serial_signed_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a, b;
  logic [5:0] result;
  logic       sel, busy, done, overflow;

  int vectors     = 0;
  int miscompares = 0;

`ifdef SUB_OVERFLOW_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  serial_signed_subtractor #(.WIDTH(4)) dut (
    .Clock   (clk),
    .Reset   (reset),
    .Start   (start),
    .A       (a),
    .B       (b),
    .Result  (result),
    .Sel     (sel),
    .Busy    (busy),
    .Done    (done),
    .Overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with Start for one edge, then drop Start.
  task automatic launch(input logic [3:0] av, input logic [3:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Tick until Done or until max cycles pass; n is the number of ticks taken.
  task automatic wait_done(input int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic stable;
    reset = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({result, sel, busy, done, overflow} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_state: got res=%b sel=%b busy=%b done=%b ovf=%b, expected all 0",
               result, sel, busy, done, overflow);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({result, sel, busy, done, overflow} !== 10'b0) stable = 1'b0;
    end
    vectors++;
    if (stable !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_idle_hold: got outputs changed=%b, expected changed=0", ~stable);
    end
  endtask

  task automatic test_basic();
    int busy_cnt;
    launch(4'd3, 4'd5);
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy === 1'b1 && done === 1'b0 && sel === 1'b0) busy_cnt++;
      tick();
    end
    vectors++;
    if (busy_cnt !== 5) begin
      miscompares++;
      $display("FAIL basic_busy_cycles: got %0d, expected 5", busy_cnt);
    end
    vectors++;
    if ({done, busy, sel} !== 3'b101) begin
      miscompares++;
      $display("FAIL basic_done_cycle6: got done/busy/sel=%b, expected 101", {done, busy, sel});
    end
    vectors++;
    if (result !== 6'b111110 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_3_minus_5: got res=%b ovf=%b, expected res=111110 ovf=0", result, overflow);
    end
    tick();
    vectors++;
    if ({done, busy, sel} !== 3'b001 || result !== 6'b111110) begin
      miscompares++;
      $display("FAIL basic_hold: got done/busy/sel=%b res=%b, expected 001 res=111110",
               {done, busy, sel}, result);
    end
  endtask

  task automatic test_boundary();
    int n;
    launch(4'b1000, 4'd7);
    wait_done(10, n);
    vectors++;
    if (done !== 1'b1 || n !== 5 || result !== 6'b110001 || overflow !== OVF_EN) begin
      miscompares++;
      $display("FAIL bound_m8_minus_7: got done=%b n=%0d res=%b ovf=%b, expected 1 5 110001 %b",
               done, n, result, overflow, OVF_EN);
    end
    tick();
    launch(4'd7, 4'b1000);
    wait_done(10, n);
    vectors++;
    if (done !== 1'b1 || n !== 5 || result !== 6'b001111 || overflow !== OVF_EN) begin
      miscompares++;
      $display("FAIL bound_7_minus_m8: got done=%b n=%0d res=%b ovf=%b, expected 1 5 001111 %b",
               done, n, result, overflow, OVF_EN);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    launch(4'd1, 4'd2);
    tick();
    tick();
    launch(4'd5, 4'b1101);   // mid-SHIFT request, must be ignored
    a = 4'd6;
    b = 4'd2;
    wait_done(10, n);
    vectors++;
    if (done !== 1'b1 || n !== 2 || result !== 6'b111111 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_ignored: got done=%b n=%0d res=%b ovf=%b, expected 1 2 111111 0",
               done, n, result, overflow);
    end
    start = 1'b1;            // held through DONE: back-to-back accept
    tick();
    start = 1'b0;
    vectors++;
    if ({done, busy, sel} !== 3'b010) begin
      miscompares++;
      $display("FAIL b2b_accept: got done/busy/sel=%b, expected 010", {done, busy, sel});
    end
    wait_done(10, n);
    vectors++;
    if (done !== 1'b1 || n !== 5 || result !== 6'b000100 || sel !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_6_minus_2: got done=%b n=%0d res=%b sel=%b, expected 1 5 000100 1",
               done, n, result, sel);
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    int   n;
    logic seen_done;
    launch(4'd2, 4'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({result, sel, busy, done, overflow} !== 10'b0) begin
      miscompares++;
      $display("FAIL abort_reset: got res=%b sel=%b busy=%b done=%b ovf=%b, expected all 0",
               result, sel, busy, done, overflow);
    end
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got activity=%b, expected 0", seen_done);
    end
    launch(4'd0, 4'd0);
    wait_done(10, n);
    vectors++;
    if (done !== 1'b1 || n !== 5 || result !== 6'b000000 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL after_abort_0_minus_0: got done=%b n=%0d res=%b ovf=%b, expected 1 5 000000 0",
               done, n, result, overflow);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    int               n;
    int               diff;
    logic signed [3:0] sa, sb;
    logic [5:0]       exp_res;
    logic             exp_ovf;
    for (int k = 0; k < 256; k++) begin
      sa = 4'(k >> 4);
      sb = 4'(k);
      diff    = int'(sa) - int'(sb);
      exp_res = 6'(diff);
      exp_ovf = OVF_EN && (diff > 7 || diff < -8);
      launch(sa, sb);        // k > 0: issued during the previous DONE cycle
      vectors++;
      if ({busy, sel} !== 2'b10) begin
        miscompares++;
        $display("FAIL exh_accept a=%0d b=%0d: got busy/sel=%b, expected 10", sa, sb, {busy, sel});
      end
      wait_done(10, n);
      vectors++;
      if (done !== 1'b1 || n !== 5 || result !== exp_res || overflow !== exp_ovf) begin
        miscompares++;
        $display("FAIL exh a=%0d b=%0d: got done=%b n=%0d res=%b ovf=%b, expected 1 5 %b %b",
                 sa, sb, done, n, result, overflow, exp_res, exp_ovf);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_reset_mid_shift();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
